// File: rtl/if_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_sequencer
// Purpose  : IF-stage sequencer for a variable-latency imem: PC enable,
//            IF/ID write/flush, one-word skid buffer, fetch timeout.
// Revision : 1.0
// ============================================================================
module if_fetch_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic        i_halt,
    output logic        o_pc_enable,
    output logic        o_ifid_write,
    output logic        o_ifid_flush,
    output logic [31:0] o_ifid_instr,
    output logic        o_halted,
    output logic        o_fetch_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] c_LAST_WAIT = CW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_REISSUE = 3'd3,
        S_HALTED  = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_buf;
    logic           r_fetch_err;
    logic           w_capture;
    logic           w_timeout;
    logic           w_cnt_clr;

    // State register, skid buffer, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_buf       <= 32'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            if (w_capture) begin
                r_buf <= i_imem_rdata;
            end
            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    // Counter only runs during un-acked FETCH cycles; held at 0 elsewhere,
    // which gives the clear-on-entry behaviour for free.
    assign w_cnt_clr = (r_state != S_FETCH) || i_imem_ack;

    always_comb begin
        w_state_nxt  = r_state;
        o_pc_enable  = 1'b0;
        o_ifid_write = 1'b0;
        o_ifid_flush = 1'b0;
        o_ifid_instr = 32'd0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = i_halt ? S_HALTED : S_FETCH;
            end

            S_FETCH: begin
                if (i_imem_ack) begin
                    if (i_redirect) begin
                        o_pc_enable  = 1'b1;
                        o_ifid_flush = 1'b1;
                    end else if (i_stall) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        o_pc_enable  = 1'b1;
                        o_ifid_write = 1'b1;
                        o_ifid_instr = i_imem_rdata;
                        if (i_halt) begin
                            w_state_nxt = S_HALTED;
                        end
                    end
                end else if (i_redirect) begin
                    o_pc_enable  = 1'b1;
                    o_ifid_flush = 1'b1;
                    w_state_nxt  = S_REISSUE;
                end else if (r_cnt == c_LAST_WAIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HALTED;
                end
            end

            S_HOLD: begin
                if (i_redirect) begin
                    o_pc_enable  = 1'b1;
                    o_ifid_flush = 1'b1;
                    w_state_nxt  = S_FETCH;
                end else if (!i_stall) begin
                    o_pc_enable  = 1'b1;
                    o_ifid_write = 1'b1;
                    o_ifid_instr = r_buf;
                    w_state_nxt  = i_halt ? S_HALTED : S_FETCH;
                end
            end

            S_REISSUE: begin
                if (i_redirect) begin
                    o_pc_enable  = 1'b1;
                    o_ifid_flush = 1'b1;
                    w_state_nxt  = S_FETCH;
                end else begin
                    w_state_nxt = i_halt ? S_HALTED : S_FETCH;
                end
            end

            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_imem_req  = (r_state == S_FETCH);
    assign o_halted    = (r_state == S_HALTED);
    assign o_fetch_err = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_sequencer
// Purpose  : Directed self-checking bench for if_fetch_sequencer (MAX_WAIT=3).
// Revision : 1.0
// ============================================================================
module tb_if_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic        halt;
    logic        pc_enable;
    logic        ifid_write;
    logic        ifid_flush;
    logic [31:0] ifid_instr;
    logic        halted;
    logic        fetch_err;

    int n_checks;
    int n_fails;

    if_fetch_sequencer #(.MAX_WAIT(3)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_imem_req   (imem_req),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_halt       (halt),
        .o_pc_enable  (pc_enable),
        .o_ifid_write (ifid_write),
        .o_ifid_flush (ifid_flush),
        .o_ifid_instr (ifid_instr),
        .o_halted     (halted),
        .o_fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge and allowed to settle.
    task automatic drive(input logic ack, input logic [31:0] data,
                         input logic stl, input logic rdr, input logic hlt);
        imem_ack   = ack;
        imem_rdata = data;
        stall      = stl;
        redirect   = rdr;
        halt       = hlt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mealy(input string tag, input logic pce, input logic wr,
                             input logic fl, input logic [31:0] ins);
        chk({tag, ".pc_en"}, {31'd0, pc_enable}, {31'd0, pce});
        chk({tag, ".wr"},    {31'd0, ifid_write}, {31'd0, wr});
        chk({tag, ".flush"}, {31'd0, ifid_flush}, {31'd0, fl});
        chk({tag, ".instr"}, ifid_instr, ins);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst.req",    {31'd0, imem_req},  32'd0);
        chk("rst.halted", {31'd0, halted},    32'd0);
        chk("rst.err",    {31'd0, fetch_err}, 32'd0);
        chk_mealy("rst", 1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Zero-wait streaming: IDLE cycle then one word per cycle.
        do_reset();
        drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        chk("t1.idle_req", {31'd0, imem_req}, 32'd0);
        chk_mealy("t1.idle", 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h11 + i, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t1.req%0d", i), {31'd0, imem_req}, 32'd1);
            chk_mealy($sformatf("t1.w%0d", i), 1'b1, 1'b1, 1'b0, 32'h11 + i);
            tick();
        end

        // Two waits, then ack with stall held for 3 cycles.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            chk_mealy($sformatf("t2.wait%0d", i), 1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        chk_mealy("t2.ackstall", 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("t2.hold_req%0d", i), {31'd0, imem_req}, 32'd0);
            chk_mealy($sformatf("t2.hold%0d", i), 1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk_mealy("t2.release", 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        tick();
        chk("t2.resume_req", {31'd0, imem_req}, 32'd1);

        // Redirect on an un-acked fetch -> one REISSUE bubble.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk_mealy("t3.redir", 1'b1, 1'b0, 1'b1, 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t3.reissue_req", {31'd0, imem_req}, 32'd0);
        chk_mealy("t3.reissue", 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        chk("t3.refetch_req", {31'd0, imem_req}, 32'd1);

        // Redirect with ack, then redirect while holding a buffered word.
        drive(1'b1, 32'hAAAA, 1'b0, 1'b1, 1'b0);
        chk_mealy("t4.ackredir", 1'b1, 1'b0, 1'b1, 32'd0);
        tick();
        chk("t4.stay_req", {31'd0, imem_req}, 32'd1);
        drive(1'b1, 32'hBBBB, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t4.hold_req", {31'd0, imem_req}, 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk_mealy("t4.holdredir", 1'b1, 1'b0, 1'b1, 32'd0);
        tick();
        chk("t4.fetch_req", {31'd0, imem_req}, 32'd1);
        drive(1'b1, 32'hCCCC, 1'b0, 1'b0, 1'b0);
        chk_mealy("t4.next", 1'b1, 1'b1, 1'b0, 32'hCCCC);
        tick();

        // Halt raised mid-wait; ack two cycles later completes the last word.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("t6.wait_req%0d", i), {31'd0, imem_req}, 32'd1);
            chk_mealy($sformatf("t6.wait%0d", i), 1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        chk_mealy("t6.last", 1'b1, 1'b1, 1'b0, 32'h55);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
            chk($sformatf("t6.halted%0d", i), {31'd0, halted}, 32'd1);
            chk($sformatf("t6.req%0d", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("t6.err%0d", i), {31'd0, fetch_err}, 32'd0);
            chk_mealy($sformatf("t6.h%0d", i), 1'b0, 1'b0, 1'b0, 32'd0);
            tick();
        end

        // Timeout with MAX_WAIT=3.
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("t5.wait2_err", {31'd0, fetch_err}, 32'd0);
        chk("t5.wait2_req", {31'd0, imem_req},  32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t5.err%0d", i),    {31'd0, fetch_err}, 32'd1);
            chk($sformatf("t5.halted%0d", i), {31'd0, halted},    32'd1);
            chk($sformatf("t5.req%0d", i),    {31'd0, imem_req},  32'd0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("t5.clr_err",    {31'd0, fetch_err}, 32'd0);
        chk("t5.clr_halted", {31'd0, halted},    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
